// File: rtl/find_top2_out.sv
// find_top2_out: buffers a score vector and scans it LANES elements per cycle to find the best
// and runner-up scores and their margin. Revision 1.0
`default_nettype none

module find_top2_out #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 2,
  parameter int SIGNED_MODE = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [31:0]                      o_max_idx,
  output logic [INPUT_WIDTH-1:0]           o_max_val,
  output logic [31:0]                      o_second_idx,
  output logic [INPUT_WIDTH-1:0]           o_second_val,
  output logic [INPUT_WIDTH:0]             o_margin,
  output logic                             o_data_valid
);

  localparam int NSCAN = (NUM_INPUT - 1 + LANES - 1) / LANES;
  localparam int CW    = (NSCAN > 1) ? $clog2(NSCAN) : 1;
  localparam int IW    = $clog2(NUM_INPUT);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t                           state_q, state_d;
  logic [NUM_INPUT*INPUT_WIDTH-1:0] buf_q, buf_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]           best_val_q, best_val_d, sec_val_q, sec_val_d;
  logic [IW-1:0]                    best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
  logic                             sec_vld_q, sec_vld_d;
  logic [IW-1:0]                    max_idx_q, max_idx_d, out_sec_idx_q, out_sec_idx_d;
  logic [INPUT_WIDTH-1:0]           max_val_q, max_val_d, out_sec_val_q, out_sec_val_d;
  logic [INPUT_WIDTH:0]             margin_q, margin_d;

  logic [INPUT_WIDTH-1:0]           ch_best_val, ch_sec_val, e_val;
  logic [IW-1:0]                    ch_best_idx, ch_sec_idx;
  logic                             ch_sec_vld;
  int                               e_pos;

  function automatic logic gt(input logic [INPUT_WIDTH-1:0] a, input logic [INPUT_WIDTH-1:0] b);
    if (SIGNED_MODE != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  function automatic logic [INPUT_WIDTH:0] ext(input logic [INPUT_WIDTH-1:0] a);
    if (SIGNED_MODE != 0) return {a[INPUT_WIDTH-1], a};
    return {1'b0, a};
  endfunction

  // Lanes form a sequential chain so the result matches one-element-at-a-time processing.
  always_comb begin
    ch_best_val = best_val_q;
    ch_best_idx = best_idx_q;
    ch_sec_val  = sec_val_q;
    ch_sec_idx  = sec_idx_q;
    ch_sec_vld  = sec_vld_q;
    e_pos       = 0;
    e_val       = '0;
    for (int l = 0; l < LANES; l++) begin
      e_pos = int'(cnt_q) * LANES + 1 + l;
      if (e_pos < NUM_INPUT) begin
        e_val = buf_q[e_pos*INPUT_WIDTH +: INPUT_WIDTH];
        if (gt(e_val, ch_best_val)) begin
          ch_sec_val  = ch_best_val;
          ch_sec_idx  = ch_best_idx;
          ch_sec_vld  = 1'b1;
          ch_best_val = e_val;
          ch_best_idx = IW'(e_pos);
        end else if (!ch_sec_vld || gt(e_val, ch_sec_val)) begin
          ch_sec_val  = e_val;
          ch_sec_idx  = IW'(e_pos);
          ch_sec_vld  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    sec_val_d     = sec_val_q;
    sec_idx_d     = sec_idx_q;
    sec_vld_d     = sec_vld_q;
    max_idx_d     = max_idx_q;
    max_val_d     = max_val_q;
    out_sec_idx_d = out_sec_idx_q;
    out_sec_val_d = out_sec_val_q;
    margin_d      = margin_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          buf_d      = i_data;
          best_val_d = i_data[INPUT_WIDTH-1:0];
          best_idx_d = '0;
          sec_val_d  = '0;
          sec_idx_d  = '0;
          sec_vld_d  = 1'b0;
          cnt_d      = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_val_d = ch_best_val;
        best_idx_d = ch_best_idx;
        sec_val_d  = ch_sec_val;
        sec_idx_d  = ch_sec_idx;
        sec_vld_d  = ch_sec_vld;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(NSCAN - 1)) begin
          state_d       = DONE;
          max_idx_d     = ch_best_idx;
          max_val_d     = ch_best_val;
          out_sec_idx_d = ch_sec_idx;
          out_sec_val_d = ch_sec_val;
          margin_d      = ext(ch_best_val) - ext(ch_sec_val);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      cnt_q         <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      sec_val_q     <= '0;
      sec_idx_q     <= '0;
      sec_vld_q     <= 1'b0;
      max_idx_q     <= '0;
      max_val_q     <= '0;
      out_sec_idx_q <= '0;
      out_sec_val_q <= '0;
      margin_q      <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      sec_val_q     <= sec_val_d;
      sec_idx_q     <= sec_idx_d;
      sec_vld_q     <= sec_vld_d;
      max_idx_q     <= max_idx_d;
      max_val_q     <= max_val_d;
      out_sec_idx_q <= out_sec_idx_d;
      out_sec_val_q <= out_sec_val_d;
      margin_q      <= margin_d;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_data_valid = (state_q == DONE);
  assign o_max_idx    = 32'(max_idx_q);
  assign o_max_val    = max_val_q;
  assign o_second_idx = 32'(out_sec_idx_q);
  assign o_second_val = out_sec_val_q;
  assign o_margin     = margin_q;

endmodule

`default_nettype wire

// File: tb/tb_find_top2_out.sv
// tb_find_top2_out: four find_top2_out configurations driven by directed vectors with a
// queue scoreboard. Revision 1.0
`default_nettype none

module tb_find_top2_out;

  localparam int NI = 10;
  localparam int W  = 16;
  localparam int ND = 4;

  typedef struct packed {
    logic [31:0] mi;
    logic [W-1:0] mv;
    logic [31:0] si;
    logic [W-1:0] sv;
    logic [W:0]   mg;
    int           acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NI*W-1:0] data = '0;
  logic [ND-1:0]   valid = '0;
  logic [ND-1:0]   ready, dv;
  logic [31:0]     mi [ND];
  logic [31:0]     si [ND];
  logic [W-1:0]    mv [ND];
  logic [W-1:0]    sv [ND];
  logic [W:0]      mg [ND];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [ND][$];
  exp_t hold [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: defaults; 1: signed; 2: one lane; 3: four lanes.
  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      find_top2_out #(
        .NUM_INPUT(NI), .INPUT_WIDTH(W),
        .LANES(g == 2 ? 1 : (g == 3 ? 4 : 2)),
        .SIGNED_MODE(g == 1 ? 1 : 0)
      ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid[g]),
        .o_ready(ready[g]), .o_max_idx(mi[g]), .o_max_val(mv[g]),
        .o_second_idx(si[g]), .o_second_val(sv[g]), .o_margin(mg[g]),
        .o_data_valid(dv[g])
      );
    end
  endgenerate

  function automatic int lat(input int g);
    return (g == 2) ? 10 : ((g == 3) ? 4 : 6);
  endfunction

  function automatic exp_t mk(input int a, input int b, input int c, input int d, input int m);
    exp_t e;
    e.mi = 32'(a); e.mv = W'(b); e.si = 32'(c); e.sv = W'(d); e.mg = (W+1)'(m); e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, g, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < ND; g++) begin
      if (rst) begin
        hold[g] = '0;
      end else if (dv[g]) begin
        if (sb[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid dut%0d actual=1 required=0", g);
        end else begin
          exp_t e;
          e = sb[g].pop_front();
          chk("max_idx", g, 128'(mi[g]), 128'(e.mi));
          chk("max_val", g, 128'(mv[g]), 128'(e.mv));
          chk("second_idx", g, 128'(si[g]), 128'(e.si));
          chk("second_val", g, 128'(sv[g]), 128'(e.sv));
          chk("margin", g, 128'(mg[g]), 128'(e.mg));
          chk("latency", g, 128'(cyc + 1 - e.acc), 128'(lat(g)));
          hold[g] = e;
        end
      end else begin
        chk("hold", g, 128'({mi[g], mv[g], si[g], sv[g], mg[g]}),
            128'({hold[g].mi, hold[g].mv, hold[g].si, hold[g].sv, hold[g].mg}));
      end
    end
  end

  task automatic send(input logic [NI*W-1:0] v, input exp_t eu, input exp_t es, input logic [ND-1:0] m);
    int n = 0;
    step();
    while ((ready & m) != m && n < 100) begin
      step();
      n++;
    end
    if ((ready & m) != m) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%0b required=%0b", ready & m, m);
    end else begin
      data  = v;
      valid = m;
      for (int g = 0; g < ND; g++) begin
        if (m[g]) begin
          exp_t e;
          e = (g == 1) ? es : eu;
          e.acc = cyc + 1;
          sb[g].push_back(e);
        end
      end
      step();
      valid = '0;
    end
  endtask

  task automatic drain();
    int n = 0;
    int pend;
    pend = 1;
    while (pend != 0 && n < 300) begin
      pend = 0;
      for (int g = 0; g < ND; g++) pend += sb[g].size();
      if (pend != 0) step();
      n++;
    end
    if (pend != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", pend);
    end
  endtask

  task automatic check_reset();
    for (int g = 0; g < ND; g++) begin
      chk("rst_outputs", g, 128'({mi[g], mv[g], si[g], sv[g], mg[g]}), 128'(0));
      chk("rst_ready", g, 128'(ready[g]), 128'(1));
      chk("rst_dv", g, 128'(dv[g]), 128'(0));
    end
  endtask

  function automatic logic [NI*W-1:0] ramp(input int base);
    logic [NI*W-1:0] v;
    for (int k = 0; k < NI; k++) v[k*W +: W] = W'(k + base);
    return v;
  endfunction

  initial begin
    logic [NI*W-1:0] v;
    int nacc;
    int last;

    repeat (2) step();
    check_reset();
    rst = 1'b0;
    step();

    send(ramp(0), mk(9, 9, 8, 8, 1), mk(9, 9, 8, 8, 1), 4'hF);

    for (int k = 0; k < NI; k++) v[k*W +: W] = 16'h0042;
    send(v, mk(0, 'h42, 1, 'h42, 0), mk(0, 'h42, 1, 'h42, 0), 4'hF);

    v = '0; v[3*W +: W] = 16'hFFFF; v[7*W +: W] = 16'h0005;
    send(v, mk(3, 'hFFFF, 7, 5, 'hFFFA), mk(7, 5, 0, 0, 5), 4'hF);

    for (int k = 0; k < NI; k++) v[k*W +: W] = W'(100 - 10 * k);
    send(v, mk(0, 100, 1, 90, 10), mk(0, 100, 1, 90, 10), 4'hF);

    v = {16'd6, 16'd4, 16'd0, 16'd8, 16'd2, 16'd9, 16'd9, 16'd3, 16'd7, 16'd1};
    send(v, mk(3, 9, 4, 9, 0), mk(3, 9, 4, 9, 0), 4'hF);

    for (int k = 0; k < NI; k++) v[k*W +: W] = 16'h8000;
    v[9*W +: W] = 16'h7FFF;
    send(v, mk(0, 'h8000, 1, 'h8000, 0), mk(9, 'h7FFF, 0, 'h8000, 'hFFFF), 4'hF);
    drain();

    // Continuous valid on instance 0: only vectors seen while ready may produce results.
    nacc = 0;
    last = -1;
    for (int n = 0; n < 21; n++) begin
      data  = ramp(n);
      valid = 4'b0001;
      if (ready[0]) begin
        exp_t e;
        e = mk(9, 9 + n, 8, 8 + n, 1);
        e.acc = cyc + 1;
        sb[0].push_back(e);
        if (last >= 0) chk("accept_spacing", 0, 128'(cyc + 1 - last), 128'(7));
        last = cyc + 1;
        nacc++;
      end
      step();
    end
    valid = '0;
    chk("accept_count", 0, 128'(nacc), 128'(3));
    drain();

    // Asynchronous reset mid-scan discards the pending result.
    send(ramp(3), mk(9, 12, 8, 11, 1), mk(9, 12, 8, 11, 1), 4'hF);
    step();
    rst = 1'b1;
    #1;
    check_reset();
    for (int g = 0; g < ND; g++) sb[g].delete();
    step();
    rst = 1'b0;

    v = '0; v[3*W +: W] = 16'hFFFF; v[7*W +: W] = 16'h0005;
    send(v, mk(3, 'hFFFF, 7, 5, 'hFFFA), mk(7, 5, 0, 0, 5), 4'hF);
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
